rr_arbiter_8: RTL and testbench

Eight-requester round-robin arbiter with a registered grant index and a bounded hold time. It sits directly upstream of the 3-to-8 decoder: `gnt_idx` drives the decoder select and `gnt_vld` drives its enable, so the decoder output is the one-hot grant vector. Fairness comes from a rotating priority pointer. A hold counter prevents any single requester from starving the others.

---
 rtl/rr_arb_pkg.sv | 23 ++
 rtl/rr_pick8.sv | 42 ++++
 rtl/rr_arbiter_8.sv | 118 +++++++++++
 tb/tb_rr_arbiter_8.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_pkg
//  Description : Shared types and constants for the 8-requester round-robin
//                arbiter (FSM state encoding, requester count, index width).
//  Revision    : 1.0  initial release
// ============================================================================
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // IDLE : no grant outstanding
  // GRANT: one requester owns the decoder enable
  // GAP  : single dead cycle between grants (decoder output all zero)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick8
//  Description : Combinational rotate-priority encoder. Returns the first set
//                bit of req found scanning upward from ptr, modulo 8.
//  Ports       : req      [7:0] in  - request vector
//                ptr      [2:0] in  - highest-priority position
//                pick_idx [2:0] out - selected requester (0 when none)
//                pick_any       out - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Candidates are visited in priority order ptr, ptr+1, ...; the 3-bit
  // addition wraps naturally from 7 back to 0.
  always_comb begin
    pick_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_any = |req;

endmodule : rr_pick8
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_8
//  Description : Eight-requester round-robin arbiter with registered grant
//                index, one dead cycle between grants and a bounded hold time.
//  Ports       : clk            in  - clock, rising edge
//                rst            in  - synchronous active-high reset
//                req     [7:0]  in  - level-held request vector
//                gnt_idx [2:0]  out - granted index (decoder select)
//                gnt_vld        out - grant active (decoder enable)
//                timeout        out - pulse in the GAP after a forced release
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_8 #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = 3,
  parameter int HOLD_MAX = 15,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  import rr_arb_pkg::arb_state_t;
  import rr_arb_pkg::IDLE;
  import rr_arb_pkg::GRANT;
  import rr_arb_pkg::GAP;

  // Last count value of a grant: the grant covers counts 0..HOLD_MAX-1.
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  arb_state_t       state_q,    state_d;
  logic [IDX_W-1:0] ptr_q,      ptr_d;
  logic [IDX_W-1:0] gnt_idx_q,  gnt_idx_d;
  logic             gnt_vld_q,  gnt_vld_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q,  timeout_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick8 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (pick_any) begin
          state_d    = GRANT;
          gnt_idx_d  = pick_idx;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          state_d    = IDLE;
        end
      end

      GRANT: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        // A drop wins over the hold limit, so timeout only fires while the
        // owner still requests.
        if (!req[gnt_idx_q]) begin
          state_d = GAP;
          ptr_d   = gnt_idx_q + IDX_W'(1);
        end else if (hold_cnt_q == C_HOLD_LAST) begin
          state_d   = GAP;
          ptr_d     = gnt_idx_q + IDX_W'(1);
          timeout_d = 1'b1;
        end else begin
          gnt_vld_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule : rr_arbiter_8
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_8
//  Description : Directed self-checking bench for rr_arbiter_8. One instance
//                uses the default hold limit (15), a second uses a limit of 2
//                for the rotation scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] req2;
  logic [2:0] gnt_idx,  gnt_idx2;
  logic       gnt_vld,  gnt_vld2;
  logic       timeout,  timeout2;
  logic [7:0] dec;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter_8 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  rr_arbiter_8 #(.HOLD_MAX(2), .HOLD_W(4)) dut_h2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req2),
    .gnt_idx (gnt_idx2),
    .gnt_vld (gnt_vld2),
    .timeout (timeout2)
  );

  // Model of the downstream 3-to-8 decoder
  always_comb dec = gnt_vld ? (8'b0000_0001 << gnt_idx) : 8'h00;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; req2 = 8'h00;
    tick(); tick();
    n_checks++; if (gnt_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld got=%0b exp=0", gnt_vld); end
    n_checks++; if (gnt_idx !== 3'd0) begin n_errors++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx); end
    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
    n_checks++; if (dut.ptr_q !== 3'd0) begin n_errors++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr_q); end
    n_checks++; if (dut.hold_cnt_q !== 4'd0) begin n_errors++; $display("FAIL reset_hold got=%0d exp=0", dut.hold_cnt_q); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 8'h04;
    #2;  // no combinational path from req to the outputs
    n_checks++; if (gnt_vld !== 1'b0) begin n_errors++; $display("FAIL single_comb_path got=%0b exp=0", gnt_vld); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd2) begin n_errors++; $display("FAIL single_grant cyc=%0d vld=%0b idx=%0d exp vld=1 idx=2", c, gnt_vld, gnt_idx); end
      n_checks++; if (dec !== 8'h04) begin n_errors++; $display("FAIL single_decoder got=%h exp=04", dec); end
    end
    req = 8'h00;
    tick();
    n_checks++; if (gnt_vld !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 3'd2) begin n_errors++; $display("FAIL single_gap vld=%0b to=%0b idx=%0d exp 0 0 2", gnt_vld, timeout, gnt_idx); end
    tick();
    n_checks++; if (gnt_vld !== 1'b0 || dut.state_q !== rr_arb_pkg::IDLE) begin n_errors++; $display("FAIL single_idle vld=%0b state=%0d exp vld=0 state=0", gnt_vld, dut.state_q); end
  endtask

  task automatic test_rotation();
    req2 = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        n_checks++; if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 3'(g % 8) || timeout2 !== 1'b0) begin n_errors++; $display("FAIL rot_grant g=%0d c=%0d vld=%0b idx=%0d to=%0b exp vld=1 idx=%0d to=0", g, c, gnt_vld2, gnt_idx2, timeout2, g % 8); end
      end
      tick();
      n_checks++; if (gnt_vld2 !== 1'b0 || timeout2 !== 1'b1) begin n_errors++; $display("FAIL rot_gap g=%0d vld=%0b to=%0b exp vld=0 to=1", g, gnt_vld2, timeout2); end
    end
    req2 = 8'h00;
    tick();
    n_checks++; if (gnt_vld2 !== 1'b0 || timeout2 !== 1'b0) begin n_errors++; $display("FAIL rot_idle vld=%0b to=%0b exp 0 0", gnt_vld2, timeout2); end
  endtask

  task automatic test_wrap();
    req = 8'h40;  // serve index 6 so ptr moves to 7
    tick();
    n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd6) begin n_errors++; $display("FAIL wrap_pre vld=%0b idx=%0d exp 1 6", gnt_vld, gnt_idx); end
    req = 8'h00;
    tick(); tick();
    n_checks++; if (dut.ptr_q !== 3'd7) begin n_errors++; $display("FAIL wrap_ptr got=%0d exp=7", dut.ptr_q); end
    req = 8'h81;
    tick();
    n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd7) begin n_errors++; $display("FAIL wrap_first vld=%0b idx=%0d exp 1 7", gnt_vld, gnt_idx); end
    req = 8'h01;
    tick();
    n_checks++; if (gnt_vld !== 1'b0 || dut.ptr_q !== 3'd0) begin n_errors++; $display("FAIL wrap_gap vld=%0b ptr=%0d exp 0 0", gnt_vld, dut.ptr_q); end
    tick();
    n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd0) begin n_errors++; $display("FAIL wrap_second vld=%0b idx=%0d exp 1 0", gnt_vld, gnt_idx); end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_drop_limit();
    req = 8'h08;
    tick();
    for (int c = 1; c < 15; c++) tick();
    // fifteenth grant cycle: count sits at HOLD_MAX-1
    n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd3 || dut.hold_cnt_q !== 4'd14) begin n_errors++; $display("FAIL droplim_pre vld=%0b idx=%0d hold=%0d exp 1 3 14", gnt_vld, gnt_idx, dut.hold_cnt_q); end
    req = 8'h00;
    tick();
    n_checks++; if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin n_errors++; $display("FAIL droplim_gap vld=%0b to=%0b exp 0 0", gnt_vld, timeout); end
    tick();
  endtask

  task automatic test_starvation();
    int found;
    int to_cyc;
    req = 8'h01;  // park ptr at 1
    tick();
    req = 8'h00;
    tick(); tick();
    req = 8'h02;
    tick();  // cycle 1 of requester 1's grant
    n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd1) begin n_errors++; $display("FAIL starve_start vld=%0b idx=%0d exp 1 1", gnt_vld, gnt_idx); end
    req = 8'h12;
    found  = -1;
    to_cyc = -1;
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (timeout === 1'b1 && to_cyc < 0) to_cyc = c;
      if (gnt_vld === 1'b1 && gnt_idx === 3'd4) begin
        found = c;
        break;
      end
    end
    // 15 grant cycles, timeout GAP in cycle 16, requester 4 in cycle 17
    n_checks++; if (found < 0 || (found - 1) > 16) begin n_errors++; $display("FAIL starve_bound got=%0d cycles exp<=16", found - 1); end
    n_checks++; if (found !== 17) begin n_errors++; $display("FAIL starve_cycle got=%0d exp=17", found); end
    n_checks++; if (to_cyc !== 16) begin n_errors++; $display("FAIL starve_timeout got=%0d exp=16", to_cyc); end
    req = 8'h02;
    tick();
    tick();
    n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd1) begin n_errors++; $display("FAIL starve_regrant vld=%0b idx=%0d exp 1 1", gnt_vld, gnt_idx); end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    req = 8'h20;
    tick();
    n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd5) begin n_errors++; $display("FAIL rstmid_pre vld=%0b idx=%0d exp 1 5", gnt_vld, gnt_idx); end
    req = 8'h21;
    rst = 1'b1;
    tick();
    n_checks++; if (gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || dut.ptr_q !== 3'd0 || timeout !== 1'b0) begin n_errors++; $display("FAIL rstmid_state vld=%0b idx=%0d ptr=%0d to=%0b exp 0 0 0 0", gnt_vld, gnt_idx, dut.ptr_q, timeout); end
    rst = 1'b0;
    tick();
    n_checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 3'd0) begin n_errors++; $display("FAIL rstmid_first vld=%0b idx=%0d exp 1 0", gnt_vld, gnt_idx); end
    req = 8'h00;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; req2 = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_drop_limit();
    test_starvation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rr_arbiter_8
`default_nettype wire
